// File: rtl/uart_receiver_if.sv
// Receive-side bundle of the UART receiver: serial line in, byte/status out.
// master = the receiver driving the byte outputs; slave = line driver / byte consumer.
interface uart_receiver_if;
   logic       rx_line;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   modport master (
      input  rx_line,
      output rx_data, rx_valid, frame_err, rx_busy
   );

   modport slave (
      output rx_line,
      input  rx_data, rx_valid, frame_err, rx_busy
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first; samples each bit at its midpoint with a
// cycle-count bit timer and reports framing errors on a bad stop bit.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic          clk,
   input  logic          reset,
   uart_receiver_if.master bus
);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    data_q, data_n;
   logic          valid_q, valid_n;
   logic          ferr_q, ferr_n;
   logic          sync1, sync2;
   logic          cnt_wrap;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= bus.rx_line;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shreg   <= shreg_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         ferr_q  <= ferr_n;
      end
   end

   assign cnt_wrap = (cnt == CNT_LAST);

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = data_q;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!sync2) state_n = START;
         end
         // Re-check the line half a bit in so short glitches are rejected.
         START: begin
            if (cnt == CNT_HALF) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = sync2 ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_wrap) begin
               cnt_n   = '0;
               shreg_n = {sync2, shreg[7:1]};
               idx_n   = idx + 1'b1;
               if (idx == 3'd7) state_n = STOP;
            end
         end
         // Leaving at the stop-bit midpoint lets a back-to-back start bit be seen.
         STOP: begin
            if (cnt_wrap) begin
               cnt_n = '0;
               if (sync2) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = WAIT_IDLE;
               end
            end
         end
         // A held-low (break) line must go high before another frame can start.
         WAIT_IDLE: begin
            cnt_n = '0;
            if (sync2) state_n = IDLE;
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.rx_busy   = (state != IDLE);
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 framing, LSB first; the receive-side counterpart of the team's UART transmitter.
- Synchronises the asynchronous rx_line and detects start bits.
- Samples each bit at its midpoint using a clock-cycle bit timer.
- Delivers each byte with a one-cycle valid pulse and flags framing errors.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit period; must be even and >= 4. HALF = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- rx_line  input  1  serial input, idle high, asynchronous to clk
- rx_data  output  8  last correctly framed byte
- rx_valid  output  1  one-cycle pulse: rx_data updated this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; both synchroniser flops=1; rx_data=0x00; rx_valid=0; frame_err=0; rx_busy=0; bit counter=0; bit index=0; shift register=0x00.
- Synchroniser: 2 flops, sync1<=rx_line, sync2<=sync1. Only sync2 feeds the FSM.
- IDLE:
  - sync2==0 at edge E0 -> START, cnt=0.
- START:
  - cnt increments each cycle.
  - At the edge where cnt==HALF-1 (edge E0+HALF): sync2==0 -> DATA with cnt=0, idx=0; else (false start/glitch) -> IDLE.
- DATA:
  - At cnt==CLKS_PER_BIT-1: shift right, sync2 enters bit 7, cnt=0, idx++.
  - After the 8th sample (idx==7): -> STOP.
  - Bit i is sampled at edge E0+HALF+(i+1)*CLKS_PER_BIT.
- STOP: at cnt==CLKS_PER_BIT-1 (edge E0+HALF+9*CLKS_PER_BIT):
  - sync2==1: rx_data<=shift register; rx_valid=1 for exactly one cycle; -> IDLE.
  - sync2==0: frame_err=1 for exactly one cycle; rx_data unchanged; rx_valid stays 0; -> WAIT_IDLE.
- WAIT_IDLE: stays until sync2==1, then -> IDLE. A held-low line (break) never starts a new frame.
- Latency: rx_line falls before edge L -> E0=L+2. rx_valid/frame_err are high in the cycle after edge L+2+HALF+9*CLKS_PER_BIT. For CLKS_PER_BIT=16 that edge is L+154.
- Back-to-back frames: IDLE is re-entered at the stop-bit midpoint, so a start bit immediately following the stop bit is detected with no extra idle time required.
- rx_valid and frame_err are registered, never both high, and never high in consecutive cycles.
- rx_data is held between frames. No consumer handshake exists; the downstream block must capture on rx_valid.
- Reset mid-frame: immediate return to reset values. Any partial byte is discarded and no pulse is emitted.

Test Plan (clk period 10 ns, CLKS_PER_BIT=16, bit time 160 ns):
- Drive frame 0xCD (line sequence start 0, then 1,0,1,1,0,0,1,1, stop 1) -> single rx_valid pulse 154 cycles after the falling edge; rx_data=0xCD; frame_err=0; rx_busy low afterwards.
- Frames 0x00 then 0xFF back-to-back with zero idle gap -> two rx_valid pulses exactly 160 cycles apart; rx_data=0x00 then 0xFF.
- rx_line low for 4 cycles, then high -> no rx_valid or frame_err; rx_busy high then low, returning to IDLE within HALF+2 cycles of the glitch.
- Frame 0x3C with stop bit 0, then line held low for 3 bit times, then high, then frame 0x81:
  - frame_err pulses once and rx_data keeps its prior value.
  - No pulse occurs during the low hold.
  - 0x81 is then received with rx_valid.
- Assert reset low during data bit 3 of frame 0x5A -> all outputs take reset values immediately with no pulse. Release reset with line high, send 0xA5 -> rx_data=0xA5, one rx_valid.
